// File: rtl/fb_draw_arbiter_if.sv
// fb_draw_arbiter_if
//  Bundles the requester-side pixel handshake and the frame buffer draw port
//  shared by fb_draw_arbiter.
//  slave  : the arbiter (consumes requests and fb_ready, drives grants and draws)
//  master : the producers / buffer side (drives requests and fb_ready)
//  Signals:
//   enable_mask  N_REQ        requesters participating in the next frame
//   req_valid    N_REQ        requester i has a pixel
//   req_index    N_REQ*IDX_W  pixel index of requester i (slice i)
//   req_color    N_REQ*COL_W  pixel colour of requester i (slice i)
//   req_done     N_REQ        pulse: requester i finished its frame
//   req_ready    N_REQ        one-hot grant
//   fb_ready     1            buffer is accepting draws
//   fb_index     IDX_W        draw index to the buffer
//   fb_data      COL_W        draw colour to the buffer
//   fb_loaded    1            frame committed
//   frame_start  1            one-cycle pulse on frame open
//   range_err    1            sticky out-of-range index flag
interface fb_draw_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 17,
  parameter int COL_W = 9
) ();
  logic [N_REQ-1:0]       enable_mask;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*IDX_W-1:0] req_index;
  logic [N_REQ*COL_W-1:0] req_color;
  logic [N_REQ-1:0]       req_done;
  logic [N_REQ-1:0]       req_ready;
  logic                   fb_ready;
  logic [IDX_W-1:0]       fb_index;
  logic [COL_W-1:0]       fb_data;
  logic                   fb_loaded;
  logic                   frame_start;
  logic                   range_err;

  modport master (
    output enable_mask, req_valid, req_index, req_color, req_done, fb_ready,
    input  req_ready, fb_index, fb_data, fb_loaded, frame_start, range_err
  );

  modport slave (
    input  enable_mask, req_valid, req_index, req_color, req_done, fb_ready,
    output req_ready, fb_index, fb_data, fb_loaded, frame_start, range_err
  );
endinterface

// File: rtl/fb_draw_arbiter.sv
// fb_draw_arbiter
//  Shares the frame buffer's single draw port among N_REQ pixel producers.
//  Pixel writes are granted round-robin; per-requester done flags are
//  tracked, and once every requester enabled for the frame is done the frame
//  is committed (fb_loaded) and the arbiter waits for the buffer clear/swap
//  before opening the next frame.
//  Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    fb_draw_arbiter_if.slave (requests, grants, draw port, status)
module fb_draw_arbiter #(
  parameter int N_REQ    = 4,
  parameter int FB_DEPTH = 96000,
  parameter int IDX_W    = 17,
  parameter int COL_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  fb_draw_arbiter_if.slave  bus
);

  localparam int          PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR      = N_REQ;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(FB_DEPTH);

  typedef enum logic [1:0] {
    WAIT_OPEN,
    DRAW,
    COMMIT,
    WAIT_SWAP
  } state_t;

  state_t             state, state_nx;
  logic [N_REQ-1:0]   active;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_ptr;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               transfer;
  logic               open_frame;
  logic               all_done;
  logic [IDX_W-1:0]   gnt_index;
  logic [COL_W-1:0]   gnt_color;
  logic               in_range;

  // Rotating-priority pick: first eligible requester at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] pos;
    logic found;
    eligible = bus.req_valid & active & ~done;
    grant    = '0;
    gnt_ptr  = '0;
    found    = 1'b0;
    idx      = 0;
    pos      = '0;
    if (state == DRAW && bus.fb_ready) begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NR) idx = idx - NR;
        pos = PTR_W'(idx);
        if (!found && eligible[pos]) begin
          found      = 1'b1;
          grant[pos] = 1'b1;
          gnt_ptr    = pos;
        end
      end
    end
  end

  assign transfer  = |grant;
  assign nxt_ptr   = (gnt_ptr == PTR_W'(N_REQ-1)) ? '0 : gnt_ptr + 1'b1;
  assign gnt_index = bus.req_index[gnt_ptr*IDX_W +: IDX_W];
  assign gnt_color = bus.req_color[gnt_ptr*COL_W +: COL_W];
  assign in_range  = {1'b0, gnt_index} < DEPTH_L;
  assign all_done  = ((active & ~done) == '0);

  assign bus.req_ready = grant;
  assign bus.fb_loaded = (state == COMMIT);

  // Commit needs a transfer-free cycle so the final pixel is already on
  // fb_index/fb_data when fb_loaded rises.
  always_comb begin
    state_nx   = state;
    open_frame = 1'b0;
    case (state)
      WAIT_OPEN, WAIT_SWAP: begin
        if (bus.fb_ready) begin
          open_frame = 1'b1;
          state_nx   = DRAW;
        end
      end
      DRAW: begin
        if (!bus.fb_ready)              state_nx = WAIT_OPEN;
        else if (all_done && !transfer) state_nx = COMMIT;
      end
      COMMIT: begin
        if (!bus.fb_ready) state_nx = WAIT_SWAP;
      end
      default: state_nx = WAIT_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_OPEN;
      active          <= '0;
      done            <= '0;
      rr_ptr          <= '0;
      bus.fb_index    <= '0;
      bus.fb_data     <= '0;
      bus.frame_start <= 1'b0;
      bus.range_err   <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.frame_start <= open_frame;
      if (open_frame) begin
        active <= bus.enable_mask;
        done   <= '0;
      end else if (state == DRAW) begin
        done <= done | (bus.req_done & active);
      end
      if (transfer) begin
        rr_ptr <= nxt_ptr;
        if (in_range) begin
          bus.fb_index <= gnt_index;
          bus.fb_data  <= gnt_color;
        end else begin
          bus.range_err <= 1'b1;
        end
      end
    end
  end

endmodule
